garage: RTL and testbench

GARAGE -- requirements
Module: garage

---
 rtl/garage.sv | 81 ++++++++
 tb/tb_garage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/garage.sv
// Garage door controller: one push-button request opens or closes the door, and the limit switches stop it.
// Latency: a request moves the state on the edge that samples it; limit switches cut the motor combinationally.
// Backpressure: none. Requests that arrive while the door is moving, or while both limit sensors are active, are dropped.
//
// Ports:
//    clk     in   single rising-edge clock
//    reset   in   synchronous, active-high reset
//    active  in   push-button / remote request (level; only its rising edge counts)
//    up_max  in   upper limit sensor, 1 = door fully open
//    dn_max  in   lower limit sensor, 1 = door fully closed
//    up_m    out  motor drive, raise door
//    dn_m    out  motor drive, lower door
module garage (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic up_max,
   input  logic dn_max,
   output logic up_m,
   output logic dn_m
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MV_UP = 2'b01,
      MV_DN = 2'b10
   } state_t;

   state_t state_q;
   logic   active_q;
   logic   act_req;
   logic   sensor_fault;

   // A level held high produces one request only.
   assign act_req      = active & ~active_q;
   // Both limits active at once is physically impossible, so the sensors are not trusted.
   assign sensor_fault = up_max & dn_max;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         active_q <= 1'b0;
      end else begin
         active_q <= active;
         case (state_q)
            IDLE: begin
               if (act_req && !sensor_fault) begin
                  // Door at the top goes down. Otherwise it goes up: either it is
                  // closed, or it is somewhere in mid-travel.
                  if (up_max) begin
                     state_q <= MV_DN;
                  end else begin
                     state_q <= MV_UP;
                  end
               end
            end
            MV_UP: begin
               if (up_max) begin
                  state_q <= IDLE;
               end
            end
            MV_DN: begin
               if (dn_max) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The motor outputs are decoded combinationally, so a limit switch stops the
   // motor in the same cycle. Unused encodings decode to both motors off.
   // MV_UP and MV_DN are separate states, so the two motors can never run
   // together.
   assign up_m = (state_q == MV_UP) & ~up_max;
   assign dn_m = (state_q == MV_DN) & ~dn_max;

endmodule

// File: tb/tb_garage.sv
// Self-checking bench for garage. Every step pushes the expected {up_m, dn_m}
// onto a queue. The bench pops that value and compares it against the DUT.
// Exclusivity of the two motor outputs is also checked on every cycle.
module tb_garage;

   logic clk;
   logic reset;
   logic active;
   logic up_max;
   logic dn_max;
   logic up_m;
   logic dn_m;

   int   total;
   int   bad;
   bit   mon_en;

   logic [1:0] exp_q[$];

   garage dut (
      .clk    (clk),
      .reset  (reset),
      .active (active),
      .up_max (up_max),
      .dn_max (dn_max),
      .up_m   (up_m),
      .dn_m   (dn_m)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive the inputs and push the expected motor outputs.
   // If clk_edge is set, wait for the next rising edge before sampling;
   // otherwise sample 1 ns later, which tests the combinational path.
   task automatic step(input logic a, input logic u, input logic d, input logic r,
                       input logic [1:0] exp, input string tag, input bit clk_edge);
      logic [1:0] e;
      active = a;
      up_max = u;
      dn_max = d;
      reset  = r;
      exp_q.push_back(exp);
      if (clk_edge) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, {up_m, dn_m}, e);
   endtask

   // Exclusivity monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (mon_en) check("excl", {1'b0, up_m & dn_m}, 2'b00);
   end

   // Watchdog.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      total  = 0;
      bad    = 0;
      mon_en = 1'b0;
      reset  = 1'b1;
      active = 1'b0;
      up_max = 1'b0;
      dn_max = 1'b1;

      // Reset state, door closed. Then hold active for 3 cycles.
      step(0, 0, 1, 1, 2'b00, "rst",        1);
      mon_en = 1'b1;
      step(1, 0, 1, 0, 2'b00, "pre_edge",   0);
      step(1, 0, 1, 0, 2'b10, "open_e1",    1);
      step(1, 0, 1, 0, 2'b10, "open_e2",    1);
      step(1, 0, 1, 0, 2'b10, "open_e3",    1);
      step(0, 0, 1, 0, 2'b10, "open_rel",   1);
      step(0, 0, 0, 0, 2'b10, "open_mid",   1);

      // Upper limit reached: the motor is cut combinationally, then the FSM goes to IDLE.
      step(0, 1, 0, 0, 2'b00, "up_cut",     0);
      step(0, 1, 0, 0, 2'b00, "up_idle",    1);
      step(0, 0, 0, 0, 2'b00, "up_idle2",   1);

      // From fully open, a 3-cycle active pulse closes the door.
      step(0, 1, 0, 0, 2'b00, "cl_pre",     1);
      step(1, 1, 0, 0, 2'b01, "close_e1",   1);
      step(1, 1, 0, 0, 2'b01, "close_e2",   1);
      step(1, 1, 0, 0, 2'b01, "close_e3",   1);
      step(0, 0, 0, 0, 2'b01, "close_mid",  1);
      step(0, 0, 1, 0, 2'b00, "dn_cut",     0);
      step(0, 0, 1, 0, 2'b00, "dn_idle",    1);
      step(0, 0, 0, 0, 2'b00, "dn_idle2",   1);

      // Mid-travel request opens the door. A second request while it is moving is ignored.
      step(1, 0, 0, 0, 2'b10, "mid_open",   1);
      step(0, 0, 0, 0, 2'b10, "mid_hold",   1);
      step(1, 0, 0, 0, 2'b10, "mid_ignore", 1);
      step(0, 1, 0, 0, 2'b00, "mid_cut",    0);
      step(0, 1, 0, 0, 2'b00, "mid_idle",   1);

      // Active held through a full open cycle: exactly one movement, and no reversal at up_max.
      step(0, 0, 1, 0, 2'b00, "hold_pre",   1);
      step(1, 0, 1, 0, 2'b10, "hold_open",  1);
      step(1, 0, 0, 0, 2'b10, "hold_mid",   1);
      step(1, 1, 0, 0, 2'b00, "hold_cut",   0);
      step(1, 1, 0, 0, 2'b00, "hold_idle",  1);
      step(1, 1, 0, 0, 2'b00, "hold_norev", 1);
      step(1, 1, 0, 0, 2'b00, "hold_norev2",1);

      // Reset while the door is moving down stops the motor.
      step(0, 1, 0, 0, 2'b00, "rd_pre",     1);
      step(1, 1, 0, 0, 2'b01, "rd_dn",      1);
      step(0, 0, 0, 0, 2'b01, "rd_mid",     1);
      step(0, 0, 0, 1, 2'b00, "rd_reset",   1);
      step(0, 0, 0, 0, 2'b00, "rd_after",   1);

      // Sensor fault: both limits active. Requests are ignored.
      step(1, 1, 1, 0, 2'b00, "fault_req",  1);
      step(0, 1, 1, 0, 2'b00, "fault_low",  1);
      step(1, 1, 1, 0, 2'b00, "fault_req2", 1);
      step(0, 1, 1, 0, 2'b00, "fault_end",  1);

      // Reset while the door is moving up.
      step(1, 0, 0, 0, 2'b10, "ru_up",      1);
      step(0, 0, 0, 1, 2'b00, "ru_reset",   1);

      // Active already high when reset is released counts as a rising edge.
      step(1, 0, 1, 1, 2'b00, "rel_rst",    1);
      step(1, 0, 1, 0, 2'b10, "rel_edge",   1);
      step(1, 1, 0, 0, 2'b00, "rel_cut",    0);
      step(0, 1, 0, 0, 2'b00, "rel_idle",   1);

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
